// File: rtl/coproc_pkg.sv
// Shared definitions for the frame buffer: state encoding, default pixel
// width, coordinate width and an address-width helper.
package coproc_pkg;

  // Coordinates from the scan controller are always 4 bits wide.
  localparam int COORD_W = 4;

  // Default pixel width.
  localparam int DATA_W_DEF = 8;

  // Frame buffer phases; the write and read sides never overlap.
  typedef enum logic [1:0] {
    EMPTY    = 2'b00,
    FILLING  = 2'b01,
    FULL     = 2'b10,
    DRAINING = 2'b11
  } fb_state_e;

  // Address width for a memory of 'depth' words, never less than one bit.
  function automatic int addr_w(input int depth);
    return (depth <= 2) ? 1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/frame_buffer_if.sv
// Pixel write port from the scan controller plus the raster output stream.
//
// Handshake: the stream side is plain valid/ready. A beat transfers on a
// rising clk edge where out_valid and out_ready are both high. Once
// out_valid rises it stays high, with out_data/out_last frozen, until that
// beat is accepted. out_ready may toggle freely and never depends on
// out_valid. The pixel port has no backpressure: pixel_valid is a one-cycle
// strobe qualified by x/y/pixel_data in the same cycle.
interface frame_buffer_if
  import coproc_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) ();

  logic               pixel_valid;
  logic [COORD_W-1:0] x;
  logic [COORD_W-1:0] y;
  logic [DATA_W-1:0]  pixel_data;

  logic               out_valid;
  logic               out_ready;
  logic [DATA_W-1:0]  out_data;
  logic               out_last;

  // Producer of pixels and consumer of the stream.
  modport master (
    output pixel_valid, x, y, pixel_data, out_ready,
    input  out_valid, out_data, out_last
  );

  // The frame buffer itself.
  modport slave (
    input  pixel_valid, x, y, pixel_data, out_ready,
    output out_valid, out_data, out_last
  );

endinterface

// File: rtl/frame_mem.sv
// Frame storage: one synchronous write port, one asynchronous read port,
// no reset so it can be swapped for a RAM macro.
module frame_mem #(
  parameter int DEPTH  = 16,
  parameter int DATA_W = 8,
  parameter int AW     = 4
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [AW-1:0]     waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [AW-1:0]     raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  // Capture a pixel on each write strobe.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/frame_buffer.sv
// Frame buffer: captures one frame of pixels addressed by x/y, flags
// completion, then streams it out in raster order. Single buffer, so
// capture and drain are strictly sequential phases of one FSM.
module frame_buffer
  import coproc_pkg::*;
#(
  parameter int img_height = 4,
  parameter int img_width  = 4,
  parameter int DATA_W     = DATA_W_DEF
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           clear,
  input  logic           drain_en,
  frame_buffer_if.slave  bus,
  output logic           frame_done,
  output logic           busy,
  output logic           overflow,
  output logic           coord_err,
  output fb_state_e      dbg_state
);

  localparam int DEPTH = img_height * img_width;
  localparam int AW    = addr_w(DEPTH);
  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);
  localparam logic [COORD_W-1:0] LAST_X = COORD_W'(img_width - 1);
  localparam logic [COORD_W-1:0] LAST_Y = COORD_W'(img_height - 1);

  fb_state_e         state_q, state_d;
  logic [AW-1:0]     rd_addr_q, rd_addr_d;
  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic              out_last_q, out_last_d;
  logic              frame_done_q, frame_done_d;
  logic              busy_q, busy_d;
  logic              overflow_q, overflow_d;
  logic              coord_err_q, coord_err_d;

  logic              in_range;
  logic              last_px;
  logic [AW-1:0]     wr_addr;
  logic [AW-1:0]     rd_sel;
  logic              mem_we;
  logic [DATA_W-1:0] mem_rdata;

  // Coordinate decode: range check, raster address, final-pixel detect.
  always_comb begin
    in_range = ({1'b0, bus.x} < (COORD_W + 1)'(img_width)) &&
               ({1'b0, bus.y} < (COORD_W + 1)'(img_height));
    last_px  = (bus.x == LAST_X) && (bus.y == LAST_Y);
    wr_addr  = AW'(({{COORD_W{1'b0}}, bus.y} * (2 * COORD_W)'(img_width)) +
                   {{COORD_W{1'b0}}, bus.x});
  end

  // The single read port serves both the first beat (address 0, fetched
  // while still FULL) and every following beat (rd_addr while DRAINING).
  assign rd_sel = (state_q == FULL) ? '0 : rd_addr_q;

  frame_mem #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W),
    .AW     (AW)
  ) u_mem (
    .clk     (clk),
    .we_i    (mem_we),
    .waddr_i (wr_addr),
    .wdata_i (bus.pixel_data),
    .raddr_i (rd_sel),
    .rdata_o (mem_rdata)
  );

  // Next-state, memory write enable and output register inputs.
  always_comb begin
    state_d      = state_q;
    rd_addr_d    = rd_addr_q;
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    out_last_d   = out_last_q;
    frame_done_d = 1'b0;
    overflow_d   = overflow_q;
    coord_err_d  = coord_err_q;
    mem_we       = 1'b0;

    if (clear) begin
      // Abort beats everything else, including a write in the same cycle.
      state_d     = EMPTY;
      rd_addr_d   = '0;
      out_valid_d = 1'b0;
      out_last_d  = 1'b0;
      overflow_d  = 1'b0;
      coord_err_d = 1'b0;
    end else begin
      unique case (state_q)
        EMPTY, FILLING: begin
          if (bus.pixel_valid) begin
            if (in_range) begin
              mem_we = 1'b1;
              // Landing on the bottom-right pixel closes the frame even if
              // earlier pixels were skipped.
              if (last_px) begin
                state_d      = FULL;
                frame_done_d = 1'b1;
              end else begin
                state_d = FILLING;
              end
            end else begin
              coord_err_d = 1'b1;
            end
          end
        end

        FULL: begin
          if (bus.pixel_valid) begin
            overflow_d = 1'b1;
          end
          if (drain_en) begin
            state_d     = DRAINING;
            out_data_d  = mem_rdata;
            out_valid_d = 1'b1;
            out_last_d  = (DEPTH == 1);
            rd_addr_d   = AW'(1);
          end
        end

        DRAINING: begin
          if (bus.pixel_valid) begin
            overflow_d = 1'b1;
          end
          if (out_valid_q && bus.out_ready) begin
            if (out_last_q) begin
              out_valid_d = 1'b0;
              out_last_d  = 1'b0;
              rd_addr_d   = '0;
              state_d     = EMPTY;
            end else begin
              out_data_d = mem_rdata;
              out_last_d = (rd_addr_q == LAST_ADDR);
              rd_addr_d  = rd_addr_q + AW'(1);
            end
          end
        end

        default: begin
          state_d = EMPTY;
        end
      endcase
    end

    // busy is registered from the next state so it has no input-to-output path.
    busy_d = (state_d != EMPTY);
  end

  // State and output registers, cleared asynchronously.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= EMPTY;
      rd_addr_q    <= '0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_last_q   <= 1'b0;
      frame_done_q <= 1'b0;
      busy_q       <= 1'b0;
      overflow_q   <= 1'b0;
      coord_err_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      rd_addr_q    <= rd_addr_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_last_q   <= out_last_d;
      frame_done_q <= frame_done_d;
      busy_q       <= busy_d;
      overflow_q   <= overflow_d;
      coord_err_q  <= coord_err_d;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_last  = out_last_q;
  assign frame_done    = frame_done_q;
  assign busy          = busy_q;
  assign overflow      = overflow_q;
  assign coord_err     = coord_err_q;
  assign dbg_state     = state_q;

endmodule
